serv_rf_ram_clr: RTL and testbench
==================================

# serv_rf_ram_clr

Register-file RAM for SERV with a hardware clear sequencer. It sits directly downstream of the register-file RAM interface and consumes its RAM-side port: write address, write data, write enable, read address, with read data returned. It holds the storage array and provides a one-cycle synchronous read. After reset, or on request, it sweeps every word to zero so that x0 and the CSR slots start from a known value. While the sweep runs it flags busy, and the top level holds the core off.

## Interface
- `width`, default 8: RAM word width; must equal the interface's `width` (2, 4, 8, 16 or 32).
- `csr_regs`, default 4: CSR slots appended after the 32 GPRs.
- `depth`, default 32*(32+csr_regs)/width: number of words.
- `aw`, default $clog2(depth): address width.

Ports (name, direction, width, meaning):
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset, asynchronous and active-high.
- `i_clr`, in, 1: request a new clear sweep (single-cycle pulse or level).
- `i_waddr`, in, aw: write address.
- `i_wdata`, in, width: write data.
- `i_wen`, in, 1: write enable.
- `i_raddr`, in, aw: read address.
- `o_rdata`, out, width: registered read data.
- `o_busy`, out, 1: sweep in progress; external writes are dropped and reads return 0.

## Operation
- FSM has two states:
  - CLEAR: write 0 to address `cnt` and increment `cnt` each cycle.
  - READY: normal RAM operation.
- Transitions:
  - Reset: state=CLEAR, `cnt`=0.
  - CLEAR with `cnt`==depth-1: the zero write to depth-1 happens, then state goes to READY.
  - READY with `i_clr`: CLEAR, `cnt`=0.
  - CLEAR with `i_clr`: `cnt`=0, restarting the sweep.
- Array write port mux:
  - In CLEAR the sequencer owns the port: addr=`cnt`, data=0, we=1. `i_wen` is ignored and the write is lost (not queued).
  - In READY the port is addr=`i_waddr`, data=`i_wdata`, we=`i_wen`.
- Read: `o_rdata` <= mem[`i_raddr`] every cycle in READY, and 0 every cycle in CLEAR.
- Read-during-write to the same address returns the old contents (read-first).
- Address width rules:
  - `cnt` is aw+1 bits wide, so the compare to depth-1 never aliases.
  - Addresses ≥ depth are not legal stimulus; behaviour for them is undefined and the bench must not drive them.
- No reset on array contents; only the sweep defines them.

## Timing
- Reset values: state=CLEAR, `cnt`=0, `o_busy`=1, `o_rdata`=0.
- `o_busy` = (state==CLEAR), driven from a register.
- Sweep duration: after reset release, `o_busy` is high for exactly `depth` rising edges (144 with default parameters). It falls in the cycle after the depth-1 write.
- `i_clr` is sampled on the clock edge. `o_busy` rises on the next edge and the sweep lasts `depth` edges again.
- Read latency is 1 cycle: `i_raddr` presented at edge N gives data on `o_rdata` after edge N+1. This matches the interface, which captures read data the cycle after it drives the address.
- Write latency is 1 cycle: a write at edge N is visible to a read issued at edge N+1.
- Reset asserted mid-sweep: the sweep aborts immediately (asynchronously) and a full sweep restarts after release.
- Reset asserted in READY: contents are preserved until the new sweep overwrites them.

## Structure
- Shared package holds `SERV_RF_DEPTH(width,csr_regs)` and the CLEAR/READY state encoding.
- One natural sub-module, `serv_rf_ram_array`: a plain 1R1W synchronous array with registered read and no reset, suitable for technology substitution. The FSM, write mux and read gating live in the top.

## Test plan
- Release reset with width=8, csr_regs=4 → `o_busy` high for exactly 144 cycles. Afterwards, reading every address 0..143 returns 0x00.
- In READY, write 0xA5 to addr 10, then read addr 10 on the next cycle → `o_rdata`=0xA5 one cycle after the address.
- Same cycle: write 0x3C to addr 7, which holds 0x11, and read addr 7 → `o_rdata`=0x11. The following read returns 0x3C.
- Fill all words with 0xFF, pulse `i_clr`, and attempt writes of 0x55 to addr 0 during the sweep → `o_rdata`=0 while busy. After 144 cycles all addresses read 0x00, including addr 0.
- Pulse `i_clr` at sweep cycle 50 → `o_busy` stays high for 144 more cycles from that edge.
- Assert `i_rst` asynchronously mid-sweep and between clock edges → `o_busy`=1 and `o_rdata`=0 immediately. After release, a full 144-cycle sweep runs.
- Repeat the first scenario with width=2 (depth=576) and width=32 (depth=36).

Source files
------------

// File: rtl/serv_rf_ram_clr_pkg.sv
// Shared definitions for the SERV register-file RAM with clear sequencer.
package serv_rf_ram_clr_pkg;

  // Words needed to hold 32 GPRs plus the CSR slots at a given word width.
  function automatic int unsigned SERV_RF_DEPTH(input int unsigned width,
                                                input int unsigned csr_regs);
    return 32 * (32 + csr_regs) / width;
  endfunction

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/serv_rf_ram_clr_if.sv
// RAM-side port of the register-file interface: one write port, one read port.
interface serv_rf_ram_clr_if #(
  parameter int unsigned width = 8,
  parameter int unsigned aw    = 8
);
  logic [aw-1:0]    i_waddr;
  logic [width-1:0] i_wdata;
  logic             i_wen;
  logic [aw-1:0]    i_raddr;
  logic [width-1:0] o_rdata;

  modport master (
    output i_waddr, i_wdata, i_wen, i_raddr,
    input  o_rdata
  );

  modport slave (
    input  i_waddr, i_wdata, i_wen, i_raddr,
    output o_rdata
  );
endinterface

// File: rtl/serv_rf_ram_array.sv
// Plain 1R1W synchronous array: registered read, read-first, no reset.
module serv_rf_ram_array #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 144,
  parameter int unsigned aw    = 8
) (
  input  logic             clk,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic             we,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  // Write and registered read; a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/serv_rf_ram_clr.sv
// Register-file RAM with a hardware sweep that zeroes every word after reset
// or on request; busy while sweeping, external writes dropped, reads gated to 0.
module serv_rf_ram_clr
  import serv_rf_ram_clr_pkg::*;
#(
  parameter int unsigned width    = 8,
  parameter int unsigned csr_regs = 4,
  parameter int unsigned depth    = SERV_RF_DEPTH(width, csr_regs),
  parameter int unsigned aw       = $clog2(depth)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  serv_rf_ram_clr_if.slave     bus,
  output logic                 o_busy
);

  localparam logic [aw:0] last_addr = (aw + 1)'(depth - 1);
  localparam logic [aw:0] cnt_one   = (aw + 1)'(1);

  state_t           state, state_next;
  logic [aw:0]      cnt, cnt_next;
  logic             mem_we;
  logic [aw-1:0]    mem_waddr;
  logic [width-1:0] mem_wdata;
  logic [width-1:0] mem_rdata;
  logic             rd_valid;

  // State register and sweep counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state: sweep to depth-1 then go ready; a clear request (re)starts at 0.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      CLEAR: begin
        if (i_clr) begin
          cnt_next = '0;
        end else if (cnt == last_addr) begin
          state_next = READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + cnt_one;
        end
      end
      READY: begin
        if (i_clr) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
    endcase
  end

  // Write port mux: the sequencer owns the array while clearing.
  always_comb begin
    mem_we    = bus.i_wen;
    mem_waddr = bus.i_waddr;
    mem_wdata = bus.i_wdata;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt[aw-1:0];
      mem_wdata = '0;
    end
  end

  serv_rf_ram_array #(
    .width (width),
    .depth (depth),
    .aw    (aw)
  ) u_array (
    .clk   (i_clk),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .we    (mem_we),
    .raddr (bus.i_raddr),
    .rdata (mem_rdata)
  );

  // The array has no reset, so read gating is tracked alongside it: the
  // flag follows the state at the capturing edge and clears asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rd_valid <= 1'b0;
    else       rd_valid <= (state == READY);
  end

  assign bus.o_rdata = rd_valid ? mem_rdata : '0;
  assign o_busy      = (state == CLEAR);

endmodule

// File: tb/tb_serv_rf_ram_clr.sv
module tb_serv_rf_ram_clr;

  localparam int unsigned D8  = 144;
  localparam int unsigned D2  = 576;
  localparam int unsigned D32 = 36;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic clr_idle = 1'b0;
  logic busy8, busy2, busy32;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q [$];
  logic [7:0]  model [D8];

  serv_rf_ram_clr_if #(.width(8),  .aw(8))  bus8  ();
  serv_rf_ram_clr_if #(.width(2),  .aw(10)) bus2  ();
  serv_rf_ram_clr_if #(.width(32), .aw(6))  bus32 ();

  serv_rf_ram_clr #(.width(8), .csr_regs(4)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .bus(bus8), .o_busy(busy8));
  serv_rf_ram_clr #(.width(2), .csr_regs(4)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr_idle), .bus(bus2), .o_busy(busy2));
  serv_rf_ram_clr #(.width(32), .csr_regs(4)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr_idle), .bus(bus32), .o_busy(busy32));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int cyc, n8, n2, n32;
    repeat (3) tick();
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 1", busy8);
    end
    n_checks++;
    if (bus8.o_rdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 00", bus8.o_rdata);
    end
    #2 rst = 1'b0;
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_release: got %b expected 1", busy8);
    end
    cyc = 0; n8 = 0; n2 = 0; n32 = 0;
    while ((busy8 || busy2 || busy32) && cyc < 1000) begin
      tick();
      cyc++;
      if (!busy8  && n8  == 0) n8  = cyc;
      if (!busy2  && n2  == 0) n2  = cyc;
      if (!busy32 && n32 == 0) n32 = cyc;
    end
    n_checks++;
    if (n8 != D8) begin
      n_fail++; $display("FAIL sweep_len_w8: got %0d expected %0d", n8, D8);
    end
    n_checks++;
    if (n2 != D2) begin
      n_fail++; $display("FAIL sweep_len_w2: got %0d expected %0d", n2, D2);
    end
    n_checks++;
    if (n32 != D32) begin
      n_fail++; $display("FAIL sweep_len_w32: got %0d expected %0d", n32, D32);
    end
    for (int i = 0; i < D8; i++) model[i] = 8'h00;
  endtask

  task automatic test_sweep_zero();
    logic [31:0] e;
    for (int i = 0; i < D8; i++) begin
      bus8.i_raddr = 8'(i);
      exp_q.push_back(32'(model[i]));
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (bus8.o_rdata !== e[7:0]) begin
        n_fail++; $display("FAIL zero_w8[%0d]: got %h expected %h", i, bus8.o_rdata, e[7:0]);
      end
    end
    for (int i = 0; i < D2; i++) begin
      bus2.i_raddr = 10'(i);
      exp_q.push_back(32'h0);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (bus2.o_rdata !== e[1:0]) begin
        n_fail++; $display("FAIL zero_w2[%0d]: got %h expected %h", i, bus2.o_rdata, e[1:0]);
      end
    end
    for (int i = 0; i < D32; i++) begin
      bus32.i_raddr = 6'(i);
      exp_q.push_back(32'h0);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (bus32.o_rdata !== e) begin
        n_fail++; $display("FAIL zero_w32[%0d]: got %h expected %h", i, bus32.o_rdata, e);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] e;
    bus8.i_wen = 1'b1; bus8.i_waddr = 8'd10; bus8.i_wdata = 8'hA5;
    model[10] = 8'hA5;
    tick();
    bus8.i_wen = 1'b0;
    bus8.i_raddr = 8'd10;
    exp_q.push_back(32'(model[10]));
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (bus8.o_rdata !== e[7:0]) begin
      n_fail++; $display("FAIL write_read: got %h expected %h", bus8.o_rdata, e[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    bit pending;
    for (int i = 0; i <= 8; i++) begin
      pending = 1'b0;
      if (i < 8) begin
        bus8.i_wen   = 1'b1;
        bus8.i_waddr = 8'(20 + i);
        bus8.i_wdata = 8'($urandom_range(1, 255));
        model[20 + i] = bus8.i_wdata;
      end else begin
        bus8.i_wen = 1'b0;
      end
      if (i > 0) begin
        bus8.i_raddr = 8'(20 + i - 1);
        exp_q.push_back(32'(model[20 + i - 1]));
        pending = 1'b1;
      end
      tick();
      if (pending) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus8.o_rdata !== e[7:0]) begin
          n_fail++; $display("FAIL back_to_back[%0d]: got %h expected %h", 20 + i - 1, bus8.o_rdata, e[7:0]);
        end
      end
    end
  endtask

  task automatic test_read_first();
    logic [31:0] e;
    bus8.i_wen = 1'b1; bus8.i_waddr = 8'd7; bus8.i_wdata = 8'h11;
    model[7] = 8'h11;
    tick();
    bus8.i_wdata = 8'h3C;
    bus8.i_raddr = 8'd7;
    exp_q.push_back(32'(model[7]));
    model[7] = 8'h3C;
    tick();
    bus8.i_wen = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (bus8.o_rdata !== e[7:0]) begin
      n_fail++; $display("FAIL read_first_old: got %h expected %h", bus8.o_rdata, e[7:0]);
    end
    exp_q.push_back(32'(model[7]));
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (bus8.o_rdata !== e[7:0]) begin
      n_fail++; $display("FAIL read_first_new: got %h expected %h", bus8.o_rdata, e[7:0]);
    end
  endtask

  task automatic test_clr_sweep();
    logic [31:0] e;
    int cyc;
    for (int i = 0; i < D8; i++) begin
      bus8.i_wen = 1'b1; bus8.i_waddr = 8'(i); bus8.i_wdata = 8'hFF;
      model[i] = 8'hFF;
      tick();
    end
    bus8.i_wen = 1'b0;
    bus8.i_raddr = 8'd143;
    exp_q.push_back(32'(model[143]));
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (bus8.o_rdata !== e[7:0]) begin
      n_fail++; $display("FAIL fill_ff: got %h expected %h", bus8.o_rdata, e[7:0]);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++; $display("FAIL clr_busy_rise: got %b expected 1", busy8);
    end
    bus8.i_wen = 1'b1; bus8.i_waddr = 8'd0; bus8.i_wdata = 8'h55;
    cyc = 0;
    while (busy8 && cyc < 1000) begin
      bus8.i_raddr = 8'(cyc % D8);
      tick();
      cyc++;
      n_checks++;
      if (bus8.o_rdata !== 8'h00) begin
        n_fail++; $display("FAIL busy_rdata[%0d]: got %h expected 00", cyc, bus8.o_rdata);
      end
    end
    bus8.i_wen = 1'b0;
    n_checks++;
    if (cyc != D8) begin
      n_fail++; $display("FAIL clr_sweep_len: got %0d expected %0d", cyc, D8);
    end
    for (int i = 0; i < D8; i++) model[i] = 8'h00;
    for (int i = 0; i < D8; i++) begin
      bus8.i_raddr = 8'(i);
      exp_q.push_back(32'(model[i]));
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (bus8.o_rdata !== e[7:0]) begin
        n_fail++; $display("FAIL after_clr[%0d]: got %h expected %h", i, bus8.o_rdata, e[7:0]);
      end
    end
  endtask

  task automatic test_clr_restart();
    int cyc;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (50) tick();
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++; $display("FAIL restart_midsweep_busy: got %b expected 1", busy8);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cyc = 0;
    while (busy8 && cyc < 1000) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != D8) begin
      n_fail++; $display("FAIL restart_len: got %0d expected %0d", cyc, D8);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] e;
    int cyc;
    bus8.i_wen = 1'b1; bus8.i_waddr = 8'd3; bus8.i_wdata = 8'h5A;
    model[3] = 8'h5A;
    tick();
    bus8.i_wen = 1'b0;
    bus8.i_raddr = 8'd3;
    exp_q.push_back(32'(model[3]));
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (bus8.o_rdata !== e[7:0]) begin
      n_fail++; $display("FAIL ready_before_rst: got %h expected %h", bus8.o_rdata, e[7:0]);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++; $display("FAIL async_rst_ready_busy: got %b expected 1", busy8);
    end
    n_checks++;
    if (bus8.o_rdata !== 8'h00) begin
      n_fail++; $display("FAIL async_rst_ready_rdata: got %h expected 00", bus8.o_rdata);
    end
    repeat (2) tick();
    rst = 1'b0;
    cyc = 0;
    while (busy8 && cyc < 1000) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != D8) begin
      n_fail++; $display("FAIL rst_ready_sweep_len: got %0d expected %0d", cyc, D8);
    end
    model[3] = 8'h00;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (30) tick();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++; $display("FAIL async_rst_sweep_busy: got %b expected 1", busy8);
    end
    n_checks++;
    if (bus8.o_rdata !== 8'h00) begin
      n_fail++; $display("FAIL async_rst_sweep_rdata: got %h expected 00", bus8.o_rdata);
    end
    repeat (2) tick();
    rst = 1'b0;
    cyc = 0;
    while (busy8 && cyc < 1000) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != D8) begin
      n_fail++; $display("FAIL rst_sweep_len: got %0d expected %0d", cyc, D8);
    end
    bus8.i_raddr = 8'd3;
    exp_q.push_back(32'(model[3]));
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (bus8.o_rdata !== e[7:0]) begin
      n_fail++; $display("FAIL cleared_after_rst: got %h expected %h", bus8.o_rdata, e[7:0]);
    end
  endtask

  initial begin
    bus8.i_wen  = 1'b0; bus8.i_waddr  = '0; bus8.i_wdata  = '0; bus8.i_raddr  = '0;
    bus2.i_wen  = 1'b0; bus2.i_waddr  = '0; bus2.i_wdata  = '0; bus2.i_raddr  = '0;
    bus32.i_wen = 1'b0; bus32.i_waddr = '0; bus32.i_wdata = '0; bus32.i_raddr = '0;
    test_reset();
    test_sweep_zero();
    test_write_read();
    test_back_to_back();
    test_read_first();
    test_clr_sweep();
    test_clr_restart();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
